hash_serializer: RTL

Output-side companion of the transaction validator. It accepts 128-bit hash results as single-cycle valid pulses (no backpressure toward the producer) and buffers them in a small FIFO. It serialises each hash MSB-first into a byte stream with valid/ready handshake, for a UART/host link. Drops on overflow are counted and flagged, never silent.

---
 rtl/hash_serializer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/hash_serializer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hash_serializer: buffers 128-bit hashes in a FIFO and streams them MSB-first
// as bytes over a valid/ready link, counting any hashes dropped on overflow.
// Revision: 1.0
// ----------------------------------------------------------------------------
module hash_serializer #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  input  logic [127:0] i_hash,
  input  logic         i_clr_stat,
  output logic         o_byte_valid,
  output logic [7:0]   o_byte,
  input  logic         i_byte_ready,
  output logic         o_last,
  output logic         o_overflow,
  output logic [7:0]   o_drop_cnt,
  output logic         o_busy
);

  localparam int               c_AW      = $clog2(DEPTH);
  localparam logic [c_AW:0]    c_FULL    = (c_AW+1)'(DEPTH);
  localparam logic [0:0]       c_ST_IDLE = 1'b0;
  localparam logic [0:0]       c_ST_SEND = 1'b1;

  logic [127:0]    r_mem [DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_AW:0]   r_count;
  logic [0:0]      r_state;
  logic [0:0]      w_state_nxt;
  logic [127:0]    r_shreg;
  logic [3:0]      r_idx;
  logic            r_overflow;
  logic [7:0]      r_drop_cnt;

  logic w_empty;
  logic w_hs;
  logic w_at_last;
  logic w_pop;
  logic w_shift;
  logic w_push;
  logic w_drop;

  assign w_empty   = (r_count == '0);
  assign w_hs      = (r_state == c_ST_SEND) && i_byte_ready;
  assign w_at_last = (r_idx == 4'd15);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign w_push    = i_valid && ((r_count != c_FULL) || w_pop);
  assign w_drop    = i_valid && !w_push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: if (!w_empty) w_state_nxt = c_ST_SEND;
      c_ST_SEND: if (w_hs && w_at_last && w_empty) w_state_nxt = c_ST_IDLE;
      default:   w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_comb begin
    w_pop        = 1'b0;
    w_shift      = 1'b0;
    o_byte_valid = 1'b0;
    o_last       = 1'b0;
    case (r_state)
      c_ST_IDLE: w_pop = !w_empty;
      c_ST_SEND: begin
        o_byte_valid = 1'b1;
        o_last       = w_at_last;
        if (w_hs) begin
          if (!w_at_last) w_shift = 1'b1;
          else            w_pop   = !w_empty;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_hash;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg <= '0;
      r_idx   <= '0;
    end else if (w_pop) begin
      r_shreg <= r_mem[r_rd_ptr];
      r_idx   <= '0;
    end else if (w_shift) begin
      r_shreg <= {r_shreg[119:0], 8'h00};
      r_idx   <= r_idx + 4'd1;
    end
  end

  // A drop coincident with a clear restarts the count at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (i_clr_stat)               r_drop_cnt <= 8'd1;
      else if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end else if (i_clr_stat) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  assign o_byte     = r_shreg[127:120];
  assign o_overflow = r_overflow;
  assign o_drop_cnt = r_drop_cnt;
  assign o_busy     = !w_empty || (r_state == c_ST_SEND);

endmodule
`default_nettype wire
